bip_control_unit: RTL and testbench

- Parametrised control unit for the accumulator CPU. It is the next generation of the PC-plus-instruction-decoder control block.
- Adds synchronous reset, run enable, HALT state, absolute branches (JMP/BEQ/BNE) and a configurable RAM read latency with pipeline stall.
- Sits between program memory (drives the fetch address, receives opcode and operand) and the datapath (accumulator mux, ALU, data RAM strobes).

---
 rtl/bip_control_unit.sv | 197 +++++++++++++++++++
 tb/tb_bip_control_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bip_control_unit                                              |
// | Purpose  : Program counter and instruction decoder for the accumulator   |
// |            CPU. It supports RUN, WAIT (RAM read latency) and HALT states |
// |            and absolute branches (JMP/BEQ/BNE).                          |
// | Ports    : clk, rst (sync, active high), en (run enable)                 |
// |            opcode, operand, acc_zero  <- program memory / datapath       |
// |            pc_addr                    -> program memory fetch address    |
// |            sel_a, sel_b, op, wr_acc   -> accumulator / ALU control       |
// |            wr_ram, rd_ram             -> data RAM strobes                |
// |            stall, halted, illegal_op  -> status                          |
// |            retired (BIP_RETIRE_COUNT_EN only) -> retired-instr count     |
// | Macro    : BIP_RETIRE_COUNT_EN adds the retired-instruction counter.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bip_control_unit #(
  parameter int ADDR_W  = 11,
  parameter int RAM_LAT = 0,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4:0]        opcode,
  input  logic [ADDR_W-1:0] operand,
  input  logic              acc_zero,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [1:0]        sel_a,
  output logic              sel_b,
  output logic              wr_acc,
  output logic              op,
  output logic              wr_ram,
  output logic              rd_ram,
  output logic              stall,
  output logic              halted,
  output logic              illegal_op
`ifdef BIP_RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  retired
`endif
);

  // A RAM read takes the issue cycle in RUN plus RAM_LAT cycles in WAIT.
  // The counter holds the number of WAIT cycles still to go after the
  // current one, so the final WAIT cycle is the one where it reads zero.
  localparam logic       c_MULTI = (RAM_LAT > 0);
  localparam logic [2:0] c_LOAD  = (RAM_LAT > 0) ? 3'(RAM_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_cnt;
  logic              r_ill;

  logic [1:0]        w_sel_a;
  logic              w_sel_b;
  logic              w_op;
  logic              w_acc_we;
  logic              w_ram_we;
  logic              w_is_rd;
  logic              w_is_hlt;
  logic              w_is_ill;
  logic              w_take;
  logic              w_run;
  logic              w_wait;
  logic              w_last;
  logic              w_go;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;

  // Instruction decode
  always_comb begin
    w_sel_a  = 2'b00;
    w_sel_b  = 1'b0;
    w_op     = 1'b0;
    w_acc_we = 1'b0;
    w_ram_we = 1'b0;
    w_is_rd  = 1'b0;
    w_is_hlt = 1'b0;
    w_is_ill = 1'b0;
    w_take   = 1'b0;
    case (opcode)
      5'b00000: w_is_hlt = 1'b1;
      5'b00001: w_ram_we = 1'b1;
      5'b00010: begin
        w_is_rd  = 1'b1;
        w_sel_a  = 2'b00;
        w_acc_we = 1'b1;
      end
      5'b00011: begin
        w_sel_a  = 2'b01;
        w_acc_we = 1'b1;
      end
      5'b00100, 5'b00110: begin
        w_is_rd  = 1'b1;
        w_sel_b  = 1'b0;
        w_sel_a  = 2'b10;
        w_op     = opcode[1];
        w_acc_we = 1'b1;
      end
      5'b00101, 5'b00111: begin
        w_sel_b  = 1'b1;
        w_sel_a  = 2'b10;
        w_op     = opcode[1];
        w_acc_we = 1'b1;
      end
      5'b01000: w_take = acc_zero;
      5'b01001: w_take = ~acc_zero;
      5'b01010: w_take = 1'b1;
      default:  w_is_ill = 1'b1;
    endcase
  end

  assign w_run     = (r_state == S_RUN);
  assign w_wait    = (r_state == S_WAIT);
  assign w_last    = w_wait && (r_cnt == 3'd0);
  assign w_go      = en & ~rst;
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_pc_next = w_take ? operand : w_pc_inc;

  // Strobes are qualified by enable and reset; selects simply follow the
  // opcode, which stays stable in WAIT because the PC holds.
  assign sel_a  = w_sel_a;
  assign sel_b  = w_sel_b;
  assign op     = w_op;
  assign wr_acc = w_go & ((w_run & w_acc_we & ~(w_is_rd & c_MULTI)) | w_last);
  assign wr_ram = w_go & w_run & w_ram_we;
  assign rd_ram = w_go & ((w_run & w_is_rd) | w_wait);
  // Not qualified by en: a frozen stall keeps reporting the stall.
  assign stall  = ~rst & ((w_run & w_is_rd & c_MULTI) | (w_wait & (r_cnt != 3'd0)));
  assign halted     = (r_state == S_HALT);
  assign pc_addr    = r_pc;
  assign illegal_op = r_ill;

`ifdef BIP_RETIRE_COUNT_EN
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  assign w_retire = w_go & ((w_run & ~w_is_hlt & ~(w_is_rd & c_MULTI)) | w_last);
  assign retired  = r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes the optional counter.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

  // Control state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_cnt   <= 3'd0;
      r_ill   <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_RUN: begin
          if (w_is_hlt) begin
            r_state <= S_HALT;
          end else if (w_is_rd && c_MULTI) begin
            r_state <= S_WAIT;
            r_cnt   <= c_LOAD;
          end else begin
            r_pc <= w_pc_next;
            if (w_is_ill) begin
              r_ill <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_pc    <= w_pc_inc;
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bip_control_unit                                           |
// | Purpose  : Scoreboard bench for bip_control_unit. Three instances share  |
// |            one input stream (RAM_LAT = 2, 3, 0); each expected entry is  |
// |            tagged with the instance it applies to.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bip_control_unit;

  localparam int NONE = -1;
  localparam int DA = 0;   // RAM_LAT = 2
  localparam int DB = 1;   // RAM_LAT = 3
  localparam int DC = 2;   // RAM_LAT = 0

  localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001, LD = 5'b00010,
                         LDI = 5'b00011, ADD = 5'b00100, ADDI = 5'b00101,
                         SUB = 5'b00110, SUBI = 5'b00111, BEQ = 5'b01000,
                         BNE = 5'b01001, JMP = 5'b01010, ILL = 5'b11111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  opcode = 5'b00011;
  logic [10:0] operand = '0;
  logic        acc_zero = 1'b0;

  logic [10:0] pc [3];
  logic [1:0]  sa [3];
  logic        sb [3], aop [3], wa [3], wr [3], rr [3], st [3], hl [3], il [3];
`ifdef BIP_RETIRE_COUNT_EN
  logic [31:0] ret [3];
`endif

  always #5 clk = ~clk;

  bip_control_unit #(.ADDR_W(11), .RAM_LAT(2), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .operand(operand),
    .acc_zero(acc_zero), .pc_addr(pc[0]), .sel_a(sa[0]), .sel_b(sb[0]),
    .wr_acc(wa[0]), .op(aop[0]), .wr_ram(wr[0]), .rd_ram(rr[0]),
    .stall(st[0]), .halted(hl[0]), .illegal_op(il[0])
`ifdef BIP_RETIRE_COUNT_EN
    , .retired(ret[0])
`endif
  );

  bip_control_unit #(.ADDR_W(11), .RAM_LAT(3), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .operand(operand),
    .acc_zero(acc_zero), .pc_addr(pc[1]), .sel_a(sa[1]), .sel_b(sb[1]),
    .wr_acc(wa[1]), .op(aop[1]), .wr_ram(wr[1]), .rd_ram(rr[1]),
    .stall(st[1]), .halted(hl[1]), .illegal_op(il[1])
`ifdef BIP_RETIRE_COUNT_EN
    , .retired(ret[1])
`endif
  );

  bip_control_unit #(.ADDR_W(11), .RAM_LAT(0), .CNT_W(32)) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .operand(operand),
    .acc_zero(acc_zero), .pc_addr(pc[2]), .sel_a(sa[2]), .sel_b(sb[2]),
    .wr_acc(wa[2]), .op(aop[2]), .wr_ram(wr[2]), .rd_ram(rr[2]),
    .stall(st[2]), .halted(hl[2]), .illegal_op(il[2])
`ifdef BIP_RETIRE_COUNT_EN
    , .retired(ret[2])
`endif
  );

  // Vector layout: {pc[10:0], sel_a[1:0], sel_b, op, wr_acc, wr_ram, rd_ram,
  //                 stall, halted, illegal_op}
  typedef struct {
    int          tag;
    logic [20:0] v;
    logic [20:0] m;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // f = {wr_acc, wr_ram, rd_ram, stall, halted, illegal_op}
  function automatic logic [20:0] mk(input logic [10:0] p, input logic [1:0] a,
                                     input logic [1:0] bo, input logic [5:0] f);
    return {p, a, bo, f};
  endfunction

  // cs = which of {sel_a, sel_b, op} the instruction defines
  task automatic step(input int tag, input logic r, input logic e,
                      input logic [4:0] opc, input logic [10:0] opr,
                      input logic az, input logic [2:0] cs,
                      input logic [20:0] v, input string name);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; opcode = opc; operand = opr; acc_zero = az;
    if (tag != NONE) begin
      x.tag  = tag;
      x.v    = v;
      x.m    = {11'h7FF, {2{cs[2]}}, cs[1], cs[0], 6'h3F};
      x.name = name;
      q.push_back(x);
    end
  endtask

  task automatic do_rst(input int tag);
    step(NONE, 1'b1, 1'b1, LDI, 11'd0, 1'b0, 3'b000, '0, "rst0");
    step(tag, 1'b1, 1'b1, LDI, 11'd0, 1'b0, 3'b000,
         mk(11'd0, 2'b00, 2'b00, 6'b000000), "reset");
  endtask

  // Monitor: every cycle with a pending expectation presents a result.
  always @(negedge clk) begin
    exp_t        e;
    logic [20:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {pc[e.tag], sa[e.tag], sb[e.tag], aop[e.tag], wa[e.tag], wr[e.tag],
             rr[e.tag], st[e.tag], hl[e.tag], il[e.tag]};
      n_checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL %s dut%0d: got %06h expected %06h (mask %06h)",
                 e.name, e.tag, act, e.v, e.m);
      end
    end
  end

  initial begin
    // ---------------- instance A, RAM_LAT = 2 ----------------
    do_rst(DA);
    step(DA, 0, 1, LDI,  11'd5, 0, 3'b100, mk(11'd0, 2'b01, 2'b00, 6'b100000), "ldi");
    step(DA, 0, 1, ADDI, 11'd3, 0, 3'b111, mk(11'd1, 2'b10, 2'b10, 6'b100000), "addi");
    step(DA, 0, 1, SUBI, 11'd1, 0, 3'b111, mk(11'd2, 2'b10, 2'b11, 6'b100000), "subi");
    step(DA, 0, 1, HLT,  11'd0, 0, 3'b000, mk(11'd3, 2'b00, 2'b00, 6'b000000), "hlt_issue");
    step(DA, 0, 1, HLT,  11'd0, 0, 3'b000, mk(11'd3, 2'b00, 2'b00, 6'b000010), "halted");
    step(DA, 0, 0, HLT,  11'd0, 0, 3'b000, mk(11'd3, 2'b00, 2'b00, 6'b000010), "halted_en0");
    step(DA, 0, 1, LDI,  11'd0, 0, 3'b000, mk(11'd3, 2'b00, 2'b00, 6'b000010), "halt_hold");
`ifdef BIP_RETIRE_COUNT_EN
    #2;
    n_checks++;
    if (ret[0] !== 32'd3) begin
      n_err++;
      $display("FAIL retired: got %0d expected 3", ret[0]);
    end
`endif
    do_rst(DA);
    step(DA, 0, 1, JMP, 11'd4, 0, 3'b000, mk(11'd0, 2'b00, 2'b00, 6'b000000), "jmp4");
    step(DA, 0, 1, LD,  11'd9, 0, 3'b100, mk(11'd4, 2'b00, 2'b00, 6'b001100), "ld_c1");
    step(DA, 0, 1, LD,  11'd9, 0, 3'b100, mk(11'd4, 2'b00, 2'b00, 6'b001100), "ld_c2");
    step(DA, 0, 1, LD,  11'd9, 0, 3'b100, mk(11'd4, 2'b00, 2'b00, 6'b101000), "ld_c3");
    step(DA, 0, 1, LDI, 11'd0, 0, 3'b100, mk(11'd5, 2'b01, 2'b00, 6'b100000), "after_ld");
    step(DA, 0, 1, LDI, 11'd0, 0, 3'b100, mk(11'd6, 2'b01, 2'b00, 6'b100000), "ldi6");
    step(DA, 0, 1, ILL, 11'd0, 0, 3'b000, mk(11'd7, 2'b00, 2'b00, 6'b000000), "illegal");
    for (int i = 0; i < 10; i++) begin
      step(DA, 0, 1, LDI, 11'd0, 0, 3'b100,
           mk(11'(8 + i), 2'b01, 2'b00, 6'b100001), "sticky");
    end
    step(DA, 0, 1, BEQ,  11'h100, 1, 3'b000, mk(11'd18,   2'b00, 2'b00, 6'b000001), "beq_taken");
    step(DA, 0, 1, BNE,  11'h100, 1, 3'b000, mk(11'h100,  2'b00, 2'b00, 6'b000001), "bne_not");
    step(DA, 0, 1, JMP,  11'h7FF, 0, 3'b000, mk(11'h101,  2'b00, 2'b00, 6'b000001), "jmp_max");
    step(DA, 0, 1, ADDI, 11'd1,   0, 3'b111, mk(11'h7FF,  2'b10, 2'b10, 6'b100001), "addi_top");
    step(DA, 0, 1, LDI,  11'd0,   0, 3'b100, mk(11'd0,    2'b01, 2'b00, 6'b100001), "wrap");
    step(DA, 0, 1, BEQ,  11'h200, 0, 3'b000, mk(11'd1,    2'b00, 2'b00, 6'b000001), "beq_not");
    step(DA, 0, 1, BNE,  11'h200, 0, 3'b000, mk(11'd2,    2'b00, 2'b00, 6'b000001), "bne_taken");
    step(DA, 0, 1, LDI,  11'd0,   0, 3'b100, mk(11'h200,  2'b01, 2'b00, 6'b100001), "at_target");
    step(DA, 0, 1, STO,  11'd0,   0, 3'b000, mk(11'h201,  2'b00, 2'b00, 6'b010001), "sto");
    step(DA, 0, 1, LD,   11'd0,   0, 3'b100, mk(11'h202,  2'b00, 2'b00, 6'b001101), "ld2_c1");
    step(DA, 0, 1, LD,   11'd0,   0, 3'b100, mk(11'h202,  2'b00, 2'b00, 6'b001101), "ld2_c2");
    step(DA, 1, 1, LD,   11'd0,   0, 3'b100, mk(11'h202,  2'b00, 2'b00, 6'b000001), "rst_in_wait");
    step(DA, 0, 1, LDI,  11'd0,   0, 3'b100, mk(11'd0,    2'b01, 2'b00, 6'b100000), "after_wait_rst");
    step(DA, 0, 1, HLT,  11'd0,   0, 3'b000, mk(11'd1,    2'b00, 2'b00, 6'b000000), "hlt2");
    step(DA, 0, 1, HLT,  11'd0,   0, 3'b000, mk(11'd1,    2'b00, 2'b00, 6'b000010), "halted2");
    step(NONE, 1, 1, HLT, 11'd0,  0, 3'b000, '0, "rst_in_halt");
    step(DA, 0, 1, LDI,  11'd0,   0, 3'b100, mk(11'd0,    2'b01, 2'b00, 6'b100000), "after_halt_rst");

    // ---------------- instance B, RAM_LAT = 3 ----------------
    do_rst(DB);
    step(DB, 0, 1, LDI, 11'd0, 0, 3'b100, mk(11'd0, 2'b01, 2'b00, 6'b100000), "b_ldi");
    step(DB, 0, 1, ADD, 11'd0, 0, 3'b111, mk(11'd1, 2'b10, 2'b00, 6'b001100), "add_c1");
    for (int i = 0; i < 4; i++) begin
      step(DB, 0, 0, ADD, 11'd0, 0, 3'b111, mk(11'd1, 2'b10, 2'b00, 6'b000100), "add_frozen");
    end
    step(DB, 0, 1, ADD, 11'd0, 0, 3'b111, mk(11'd1, 2'b10, 2'b00, 6'b001100), "add_c2");
    step(DB, 0, 1, ADD, 11'd0, 0, 3'b111, mk(11'd1, 2'b10, 2'b00, 6'b001100), "add_c3");
    step(DB, 0, 1, ADD, 11'd0, 0, 3'b111, mk(11'd1, 2'b10, 2'b00, 6'b101000), "add_c4");
    step(DB, 0, 0, LDI, 11'd0, 0, 3'b100, mk(11'd2, 2'b01, 2'b00, 6'b000000), "ldi_en0");
    step(DB, 0, 1, LDI, 11'd0, 0, 3'b100, mk(11'd2, 2'b01, 2'b00, 6'b100000), "ldi_resume");
    step(DB, 0, 1, LDI, 11'd0, 0, 3'b100, mk(11'd3, 2'b01, 2'b00, 6'b100000), "ldi_next");

    // ---------------- instance C, RAM_LAT = 0 ----------------
    do_rst(DC);
    step(DC, 0, 1, LD,  11'd0, 0, 3'b100, mk(11'd0, 2'b00, 2'b00, 6'b101000), "ld_lat0");
    step(DC, 0, 1, SUB, 11'd0, 0, 3'b111, mk(11'd1, 2'b10, 2'b01, 6'b101000), "sub_lat0");
    step(DC, 0, 1, STO, 11'd0, 0, 3'b000, mk(11'd2, 2'b00, 2'b00, 6'b010000), "sto_c");
    step(DC, 0, 1, HLT, 11'd0, 0, 3'b000, mk(11'd3, 2'b00, 2'b00, 6'b000000), "hlt_c");
    step(DC, 0, 1, HLT, 11'd0, 0, 3'b000, mk(11'd3, 2'b00, 2'b00, 6'b000010), "halted_c");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
